// File: rtl/rr_arb_mux_pkg.sv
// Shared CPU package: machine word width and the index-width helper used to
// size channel selectors.
//   XLEN  - native data word width (default payload width of the arbiter)
//   clog2 - max(1, ceil(log2(value))), width needed to index 'value' items
package rr_arb_mux_pkg;

  localparam int XLEN = 32'sd32;

  function automatic int clog2(input int value);
    int res;
    res = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 32'sd1;
      end else begin
        res = res;
      end
    end
    // A single-item index still needs one bit of select
    if (res < 32'sd1) begin
      res = 32'sd1;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// rr_pick: combinational round-robin search.
//   ptr   - index where the search starts (always below N)
//   req   - per-channel request bits
//   grant - one-hot grant (all zeros when nothing is requested)
//   gidx  - index of the granted channel (0 when nothing is requested)
//   any   - at least one request bit is set
module rr_pick
  import rr_arb_mux_pkg::*;
#(
  parameter  int N   = 2,
  localparam int IDW = clog2(N)
) (
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gidx,
  output logic           any
);

  int             sum_s;
  logic [IDW-1:0] idx_s;

  // Walk ptr, ptr+1, ... with an explicit wrap at N; the first set bit wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    sum_s = 32'sd0;
    idx_s = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = int'(ptr) + k;
      // Wrap at N rather than at 2**IDW so non-power-of-two N never aliases
      if (sum_s >= N) begin
        sum_s = sum_s - N;
      end else begin
        sum_s = sum_s;
      end
      idx_s = IDW'(sum_s);
      if (!any && req[idx_s]) begin
        any          = 1'b1;
        grant[idx_s] = 1'b1;
        gidx         = idx_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbiter feeding a single output register.
//   clk, rst   - clock and synchronous active-high reset
//   req_valid  - per-channel request valid
//   req_data   - packed payloads, channel i at [i*WIDTH +: WIDTH]
//   req_ready  - per-channel accept strobe (at most one bit set)
//   out_valid  - output register holds a word
//   out_data   - registered payload
//   out_sel    - channel that sourced out_data
//   out_ready  - consumer accepts the output word
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int WIDTH = XLEN,
  parameter  int N     = 2,
  localparam int IDW   = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDW-1:0]     out_sel,
  input  logic               out_ready
);

  logic [IDW-1:0]   ptr_r;
  logic [N-1:0]     grant_s;
  logic [IDW-1:0]   gidx_s;
  logic             any_s;
  logic             load_en_s;
  logic [IDW-1:0]   ptr_next_s;
  logic [WIDTH-1:0] words_s [N];
  logic [WIDTH-1:0] sel_data_s;

  rr_pick #(.N(N)) u_pick (
    .ptr   (ptr_r),
    .req   (req_valid),
    .grant (grant_s),
    .gidx  (gidx_s),
    .any   (any_s)
  );

  // The output register can take a new word when empty or being drained
  assign load_en_s = ~out_valid | out_ready;

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words_s[i] = req_data[i*WIDTH +: WIDTH];
  end

  // req_data only reaches the register input, never an output directly
  assign sel_data_s = words_s[gidx_s];

  // Accept strobe: the granted channel, only when the register can load
  always_comb begin
    if (rst) begin
      req_ready = '0;
    end else if (load_en_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next search start is one past the winner, wrapping explicitly at N
  always_comb begin
    if (gidx_s == IDW'(N - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gidx_s + IDW'(1);
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_r     <= '0;
    end else if (load_en_s && any_s) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_s;
      out_sel   <= gidx_s;
      ptr_r     <= ptr_next_s;
    end else if (load_en_s) begin
      // Drained with nothing pending: drop valid, keep the last payload
      out_valid <= 1'b0;
      out_data  <= out_data;
      out_sel   <= out_sel;
      ptr_r     <= ptr_r;
    end else begin
      out_valid <= out_valid;
      out_data  <= out_data;
      out_sel   <= out_sel;
      ptr_r     <= ptr_r;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (N=2/W=32, N=3/W=32, N=5/W=8)
// compared every cycle against a behavioural model, directed literal
// scenarios on the first two, randomized traffic with a scoreboard on N=5.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=2, WIDTH=32
  logic        rst2 = 1'b1, r2 = 1'b0, ov2;
  logic [1:0]  v2 = 2'b00, rdy2;
  logic [63:0] d2 = 64'h0;
  logic [31:0] od2;
  logic [0:0]  os2;
  // N=3, WIDTH=32
  logic        rst3 = 1'b1, r3 = 1'b0, ov3;
  logic [2:0]  v3 = 3'b000, rdy3;
  logic [95:0] d3 = 96'h0;
  logic [31:0] od3;
  logic [1:0]  os3;
  // N=5, WIDTH=8
  logic        rst5 = 1'b1, r5 = 1'b0, ov5;
  logic [4:0]  v5 = 5'b0, rdy5, acc5 = 5'b0;
  logic [39:0] d5 = 40'h0;
  logic [7:0]  od5;
  logic [2:0]  os5;

  rr_arb_mux #(.WIDTH(32), .N(2)) dut2 (.clk(clk), .rst(rst2), .req_valid(v2), .req_data(d2),
    .req_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(r2));
  rr_arb_mux #(.WIDTH(32), .N(3)) dut3 (.clk(clk), .rst(rst3), .req_valid(v3), .req_data(d3),
    .req_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(r3));
  rr_arb_mux #(.WIDTH(8), .N(5)) dut5 (.clk(clk), .rst(rst5), .req_valid(v5), .req_data(d5),
    .req_ready(rdy5), .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(r5));

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;
  bit sb_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int     m_ptr [3];
  bit     m_ov  [3];
  longint m_od  [3];
  int     m_os  [3];
  longint dd    [8];

  // First requesting channel at or after p, going round the ring of n
  function automatic int pick(input int n, input int p, input logic [7:0] v);
    for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  task automatic model_cycle(input int k, input int n, input logic rst_i, input logic [7:0] v,
                             input logic ordy, input logic [7:0] drr, input logic dov,
                             input logic [63:0] dod, input int dos);
    int g;
    bit le;
    logic [7:0] er;
    string nm;
    nm = $sformatf("n%0d ", n);
    g  = pick(n, m_ptr[k], v);
    le = !m_ov[k] || ordy;
    er = 8'h00;
    if (!rst_i && le && g >= 0) er = 8'h01 << g;
    chk({nm, "req_ready"}, drr, er);
    chk({nm, "out_valid"}, dov, m_ov[k]);
    chk({nm, "out_data"},  dod, m_od[k]);
    chk({nm, "out_sel"},   64'(dos), 64'(m_os[k]));
    if (rst_i) begin
      m_ov[k] = 1'b0; m_od[k] = 0; m_os[k] = 0; m_ptr[k] = 0;
    end else if (le && g >= 0) begin
      m_ov[k] = 1'b1; m_od[k] = dd[g]; m_os[k] = g; m_ptr[k] = (g + 1) % n;
    end else if (le) begin
      m_ov[k] = 1'b0;
    end
  endtask

  longint sbq[$];
  int     wait_cnt [5];

  // Compare process: every DUT against the model, plus the N=5 scoreboard
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 8; i++) dd[i] = 0;
      for (int i = 0; i < 2; i++) dd[i] = longint'(d2[i*32 +: 32]);
      model_cycle(0, 2, rst2, {6'b0, v2}, r2, {6'b0, rdy2}, ov2, {32'b0, od2}, int'(os2));
      for (int i = 0; i < 8; i++) dd[i] = 0;
      for (int i = 0; i < 3; i++) dd[i] = longint'(d3[i*32 +: 32]);
      model_cycle(1, 3, rst3, {5'b0, v3}, r3, {5'b0, rdy3}, ov3, {32'b0, od3}, int'(os3));
      for (int i = 0; i < 8; i++) dd[i] = 0;
      for (int i = 0; i < 5; i++) dd[i] = longint'(d5[i*8 +: 8]);
      model_cycle(2, 5, rst5, {3'b0, v5}, r5, {3'b0, rdy5}, ov5, {56'b0, od5}, int'(os5));
      chk("n3 ptr below N", 64'(dut3.ptr_r < 2'd3), 64'd1);
      chk("n5 ptr below N", 64'(dut5.ptr_r < 3'd5), 64'd1);
      chk("n5 req_ready onehot0", 64'($onehot0(rdy5)), 64'd1);
      acc5 = rdy5 & v5;
      if (sb_en) begin
        if (ov5 && r5) begin
          chk("n5 sb word expected", 64'(sbq.size() > 0), 64'd1);
          if (sbq.size() > 0) chk("n5 sb word", 64'({os5, od5}), sbq.pop_front());
        end
        for (int i = 0; i < 5; i++) begin
          if (acc5[i]) begin
            sbq.push_back((longint'(i) << 8) | longint'(d5[i*8 +: 8]));
            chk("n5 starvation bound", 64'(wait_cnt[i] <= 4), 64'd1);
            wait_cnt[i] = 0;
          end else if (v5[i]) begin
            if (acc5 != 5'b0) wait_cnt[i]++;
          end else begin
            wait_cnt[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tick();
    cmp_en = 1'b1;
    tick();
    chk("n2 reset out_valid", 64'(ov2), 64'd0);
    chk("n2 reset out_data",  64'(od2), 64'd0);
    chk("n2 reset out_sel",   64'(os2), 64'd0);
    chk("n3 reset ptr",       64'(dut3.ptr_r), 64'd0);

    // N=2 alternation, one word per cycle
    rst2 = 1'b0; v2 = 2'b11; d2 = {32'hBBBB0000, 32'hAAAA0000}; r2 = 1'b1;
    #1 chk("n2 first ready", 64'(rdy2), 64'h1);
    tick();
    chk("n2 word0 valid", 64'(ov2), 64'd1);
    chk("n2 word0 sel",   64'(os2), 64'd0);
    chk("n2 word0 data",  64'(od2), 64'hAAAA0000);
    tick();
    chk("n2 word1 sel",   64'(os2), 64'd1);
    chk("n2 word1 data",  64'(od2), 64'hBBBB0000);
    tick();
    chk("n2 word2 sel",   64'(os2), 64'd0);
    chk("n2 word2 data",  64'(od2), 64'hAAAA0000);
    chk("n2 next ready",  64'(rdy2), 64'h2);
    v2 = 2'b00;
    tick();
    chk("n2 drained valid", 64'(ov2), 64'd0);

    // N=3 backpressure then resume
    rst3 = 1'b0; v3 = 3'b111; d3 = {32'h33333333, 32'h22222222, 32'h11111111}; r3 = 1'b0;
    #1 chk("n3 first ready", 64'(rdy3), 64'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("n3 stall valid", 64'(ov3), 64'd1);
      chk("n3 stall data",  64'(od3), 64'h11111111);
      chk("n3 stall ready", 64'(rdy3), 64'h0);
      tick();
    end
    r3 = 1'b1;
    #1 chk("n3 resume ready", 64'(rdy3), 64'h2);
    tick();
    chk("n3 resume sel1",  64'(os3), 64'd1);
    chk("n3 resume data1", 64'(od3), 64'h22222222);
    tick();
    chk("n3 resume sel2",  64'(os3), 64'd2);
    chk("n3 resume data2", 64'(od3), 64'h33333333);

    // N=3 wrap from ptr=2 to ch0
    v3 = 3'b010;
    tick();
    chk("n3 ptr after ch1", 64'(dut3.ptr_r), 64'd2);
    v3 = 3'b001;
    #1 chk("n3 wrap ready", 64'(rdy3), 64'h1);
    tick();
    chk("n3 wrap sel",  64'(os3), 64'd0);
    chk("n3 wrap ptr",  64'(dut3.ptr_r), 64'd1);

    // Single word: valid for one cycle, payload retained
    v3 = 3'b000;
    tick();
    chk("n3 single valid low", 64'(ov3), 64'd0);
    chk("n3 single data held", 64'(od3), 64'h11111111);
    tick();
    chk("n3 idle data held", 64'(od3), 64'h11111111);
    chk("n3 idle sel held",  64'(os3), 64'd0);

    // Reset during a stalled transfer discards the word
    v3 = 3'b111; r3 = 1'b0;
    tick();
    chk("n3 pre-reset sel", 64'(os3), 64'd1);
    rst3 = 1'b1;
    #1 chk("n3 reset ready", 64'(rdy3), 64'h0);
    tick();
    chk("n3 mid reset valid", 64'(ov3), 64'd0);
    chk("n3 mid reset data",  64'(od3), 64'd0);
    chk("n3 mid reset sel",   64'(os3), 64'd0);
    chk("n3 mid reset ptr",   64'(dut3.ptr_r), 64'd0);
    rst3 = 1'b0; v3 = 3'b000; r3 = 1'b1;
    tick();
    chk("n3 no replay", 64'(ov3), 64'd0);

    // N=5 randomized traffic
    rst5 = 1'b0;
    tick();
    sbq.delete();
    for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
    sb_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (v5[i] && !acc5[i]) begin
          if ($urandom_range(15, 0) == 0) v5[i] = 1'b0;
        end else begin
          v5[i] = ($urandom_range(1, 0) == 1);
          d5[i*8 +: 8] = 8'($urandom);
        end
      end
      r5 = ($urandom_range(3, 0) != 0);
      tick();
    end
    v5 = 5'b0; r5 = 1'b1;
    tick(); tick(); tick();
    chk("n5 sb empty at end", 64'(sbq.size()), 64'd0);
    chk("n5 drained valid",   64'(ov5), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
